// File: rtl/control_ins_multi_if.sv
// Byte-stream FIFO port for the instruction decoder: first-word-fall-through head,
// empty flag and pop strobe.
interface control_ins_multi_if;
    logic [7:0] in_read;
    logic       em_read;
    logic       pp_read;

    modport master (output in_read, output em_read, input pp_read);
    modport slave  (input in_read, input em_read, output pp_read);
endinterface

// File: rtl/control_ins_multi.sv
// Multi-byte instruction decoder: pops opcode/operand bytes from a FWFT FIFO and
// updates module-enable, digital, prescaler and analog-channel registers.
module control_ins_multi #(
    parameter int DW      = 8,
    parameter int AW      = 12,
    parameter int NCH     = 2,
    parameter int PW      = 10,
    parameter int MW      = 5,
    parameter int TIMEOUT = 256
) (
    input  logic                clk,
    input  logic                rst,
    control_ins_multi_if.slave  fifo,
    output logic [MW-1:0]       activemods,
    output logic [DW-1:0]       dout,
    output logic [PW-1:0]       pre,
    output logic [NCH*AW-1:0]   aout,
    output logic [NCH-1:0]      aout_upd,
    output logic                busy,
    output logic                err,
    output logic [1:0]          err_code
);
    typedef enum logic [1:0] {IDLE, OP1, OP2} state_t;

    localparam logic [2:0] OP_ACT  = 3'b000;
    localparam logic [2:0] OP_DIG  = 3'b001;
    localparam logic [2:0] OP_ANA  = 3'b010;
    localparam logic [2:0] OP_PRE  = 3'b011;
    localparam logic [2:0] OP_NOP  = 3'b100;

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TLAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t        state, state_nx;
    logic [TW-1:0] tcnt;
    logic [2:0]    op_r;
    logic [3:0]    ch_r;
    logic [7:0]    b1_r;
    logic          pop, tmo, tmo_hit, ch_ok;
    logic [2:0]    op;
    logic [4:0]    arg;
    logic [15:0]   word;

    assign pop          = !fifo.em_read && !rst;
    assign fifo.pp_read = pop;
    assign op           = fifo.in_read[7:5];
    assign arg          = fifo.in_read[4:0];
    assign word         = {b1_r, fifo.in_read};
    assign ch_ok        = {1'b0, ch_r} < 5'(NCH);
    assign tmo_hit      = (TIMEOUT > 0) && (tcnt == TLAST);

    always_comb begin
        state_nx = state;
        tmo      = 1'b0;
        case (state)
            IDLE: if (pop && (op == OP_DIG || op == OP_ANA || op == OP_PRE)) state_nx = OP1;
            OP1: begin
                if (pop) state_nx = (op_r == OP_DIG) ? IDLE : OP2;
                else if (tmo_hit) begin
                    state_nx = IDLE;
                    tmo      = 1'b1;
                end
            end
            OP2: begin
                if (pop) state_nx = IDLE;
                else if (tmo_hit) begin
                    state_nx = IDLE;
                    tmo      = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Empty-cycle counter only runs while waiting for operands.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            tcnt  <= '0;
            busy  <= 1'b0;
        end else begin
            state <= state_nx;
            busy  <= (state_nx != IDLE);
            if (pop || state == IDLE || state_nx != state) tcnt <= '0;
            else tcnt <= tcnt + TW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            activemods <= '0;
            dout       <= '0;
            pre        <= '0;
            aout       <= '0;
            aout_upd   <= '0;
            err        <= 1'b0;
            err_code   <= 2'b00;
            op_r       <= '0;
            ch_r       <= '0;
            b1_r       <= '0;
        end else begin
            aout_upd <= '0;
            err      <= 1'b0;
            if (tmo) begin
                err      <= 1'b1;
                err_code <= 2'b11;
            end
            if (pop) begin
                case (state)
                    IDLE: begin
                        case (op)
                            OP_ACT: activemods <= MW'(arg);
                            OP_DIG, OP_ANA, OP_PRE: begin
                                op_r <= op;
                                ch_r <= arg[3:0];
                            end
                            OP_NOP: ;
                            default: begin
                                err      <= 1'b1;
                                err_code <= 2'b01;
                            end
                        endcase
                    end
                    OP1: begin
                        if (op_r == OP_DIG) dout <= DW'(fifo.in_read);
                        else b1_r <= fifo.in_read;
                    end
                    OP2: begin
                        if (op_r == OP_ANA) begin
                            if (ch_ok) begin
                                for (int k = 0; k < NCH; k++) begin
                                    if (ch_r == 4'(k)) begin
                                        aout[k*AW +: AW] <= AW'(word);
                                        aout_upd[k]      <= 1'b1;
                                    end
                                end
                            end else begin
                                err      <= 1'b1;
                                err_code <= 2'b10;
                            end
                        end else begin
                            pre <= PW'(word);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule
